csr_timer_unit: RTL and testbench

- Timer and stable-counter slice of the CSR file. Owns TCFG, TVAL, TICLR, TID and the 64-bit stable counter.
- Produces the timer interrupt bit for ESTAT.IS[11] and the counter values consumed by the RDCNT path in WB.
- Sits beside the main CSR register block. It is fed by the same WB-stage CSR write port (csrnum, wdata, wen) built from CsrCtrl.

---
 rtl/csr_timer_unit_pkg.sv | 23 ++
 rtl/csr_timer_unit_stable_counter64.sv | 23 ++
 rtl/csr_timer_unit.sv | 137 +++++++++++++
 tb/tb_csr_timer_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_timer_unit_pkg.sv
// Shared definitions for the CSR timer slice: CSR addresses, field masks and
// the TCFG field layout.
package csr_timer_unit_pkg;

  localparam int TIMESIZE = 12;
  localparam int TI_BIT   = 11;

  localparam logic [13:0] CSR_TID   = 14'h0040;
  localparam logic [13:0] CSR_TCFG  = 14'h0041;
  localparam logic [13:0] CSR_TVAL  = 14'h0042;
  localparam logic [13:0] CSR_TICLR = 14'h0044;

  localparam logic [31:0] TCFG_WM = 32'((64'd1 << (TIMESIZE + 2)) - 64'd1);
  localparam logic [31:0] TID_WM  = 32'hFFFF_FFFF;
  localparam logic [TIMESIZE+1:0] TVAL_RM = {(TIMESIZE + 2){1'b1}};

  typedef struct packed {
    logic [TIMESIZE-1:0] init_val;
    logic                periodic;
    logic                en;
  } tcfg_fields_t;

endpackage

// File: rtl/csr_timer_unit_stable_counter64.sv
// Free-running 64-bit stable counter, split into 32-bit halves for RDCNTVL/VH.
module stable_counter64 (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  logic [63:0] cnt_r;

  // count every cycle, wrapping naturally at 2^64
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 64'd0;
    end else begin
      cnt_r <= cnt_r + 64'd1;
    end
  end

  assign lo = cnt_r[31:0];
  assign hi = cnt_r[63:32];

endmodule

// File: rtl/csr_timer_unit.sv
// Timer CSRs (TCFG/TVAL/TICLR/TID), timer interrupt flag and stable counter,
// sitting beside the main CSR block on the same WB-stage write port.
module csr_timer_unit
  import csr_timer_unit_pkg::*;
#(
  parameter logic [31:0] TID_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_rhit,
  output logic        timer_int,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi,
  output logic [31:0] tid
);

  localparam int TW = TIMESIZE + 2;
  localparam logic [TW-1:0] TVAL_ONE = TW'(1);
  localparam logic [TIMESIZE-1:0] INIT_ZERO = {TIMESIZE{1'b0}};

  tcfg_fields_t  tcfg_r;
  tcfg_fields_t  tcfg_next_s;
  tcfg_fields_t  tcfg_wdata_s;
  logic [TW-1:0] tval_r;
  logic [TW-1:0] tval_next_s;
  logic          ti_r;
  logic          ti_next_s;
  logic          ti_set_s;
  logic [31:0]   tid_r;
  logic          tcfg_wr_s;
  logic          ticlr_wr_s;
  logic          tid_wr_s;

  assign tcfg_wr_s    = csr_we && (csr_waddr == CSR_TCFG);
  assign ticlr_wr_s   = csr_we && (csr_waddr == CSR_TICLR) && csr_wdata[0];
  assign tid_wr_s     = csr_we && (csr_waddr == CSR_TID);
  assign tcfg_wdata_s = tcfg_fields_t'(csr_wdata[TW-1:0] & TCFG_WM[TW-1:0]);

  // countdown / reload / one-shot expiry and the TI set condition
  always_comb begin
    tcfg_next_s = tcfg_r;
    tval_next_s = tval_r;
    ti_set_s    = 1'b0;
    if (tcfg_wr_s) begin
      // the write overrides TVAL/En, but an expiry this cycle still raises TI
      tcfg_next_s = tcfg_wdata_s;
      tval_next_s = {tcfg_wdata_s.init_val, 2'b00};
      ti_set_s    = (tcfg_r.en && (tval_r == TVAL_ONE)) ||
                    (tcfg_wdata_s.en && (tcfg_wdata_s.init_val == INIT_ZERO));
    end else if (tcfg_r.en) begin
      if (tval_r != {TW{1'b0}}) begin
        tval_next_s = tval_r - TVAL_ONE;
        ti_set_s    = (tval_r == TVAL_ONE);
      end else if (tcfg_r.periodic) begin
        tval_next_s = {tcfg_r.init_val, 2'b00};
        ti_set_s    = (tcfg_r.init_val == INIT_ZERO);
      end else begin
        tcfg_next_s.en = 1'b0;
      end
    end else begin
      tval_next_s = tval_r;
    end
  end

  // set beats clear when both land in the same cycle
  always_comb begin
    ti_next_s = ti_r;
    if (ti_set_s) begin
      ti_next_s = 1'b1;
    end else if (ticlr_wr_s) begin
      ti_next_s = 1'b0;
    end else begin
      ti_next_s = ti_r;
    end
  end

  // timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg_r <= tcfg_fields_t'({TW{1'b0}});
      tval_r <= {TW{1'b0}};
      ti_r   <= 1'b0;
      tid_r  <= TID_RESET;
    end else begin
      tcfg_r <= tcfg_next_s;
      tval_r <= tval_next_s;
      ti_r   <= ti_next_s;
      if (tid_wr_s) begin
        tid_r <= csr_wdata & TID_WM;
      end
    end
  end

  // read mux over registered state only, so a write is not visible until the next cycle
  always_comb begin
    csr_rdata = 32'h0000_0000;
    csr_rhit  = 1'b0;
    case (csr_raddr)
      CSR_TCFG: begin
        csr_rdata = {{(32 - TW){1'b0}}, tcfg_r};
        csr_rhit  = 1'b1;
      end
      CSR_TVAL: begin
        csr_rdata = {{(32 - TW){1'b0}}, tval_r & TVAL_RM};
        csr_rhit  = 1'b1;
      end
      CSR_TICLR: begin
        csr_rdata = 32'h0000_0000;
        csr_rhit  = 1'b1;
      end
      CSR_TID: begin
        csr_rdata = tid_r;
        csr_rhit  = 1'b1;
      end
      default: begin
        csr_rdata = 32'h0000_0000;
        csr_rhit  = 1'b0;
      end
    endcase
  end

  stable_counter64 u_stable_counter (
    .clk (clk),
    .rst (rst),
    .lo  (cnt_lo),
    .hi  (cnt_hi)
  );

  assign timer_int = ti_r;
  assign tid       = tid_r;

endmodule

// File: tb/tb_csr_timer_unit.sv
// Self-checking bench for csr_timer_unit: directed scenarios plus randomized
// CSR traffic compared against a behavioural timer model.
module tb_csr_timer_unit;
  import csr_timer_unit_pkg::*;

  localparam logic [31:0] TID_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_rhit;
  logic        timer_int;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;
  logic [31:0] tid;

  always #5 clk = ~clk;

  csr_timer_unit #(.TID_RESET(TID_RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .csr_we    (csr_we),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .csr_rhit  (csr_rhit),
    .timer_int (timer_int),
    .cnt_lo    (cnt_lo),
    .cnt_hi    (cnt_hi),
    .tid       (tid)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_valid = 1'b0;
  bit          m_en;
  bit          m_per;
  int unsigned m_init;
  int unsigned m_tval;
  bit          m_ti;
  logic [63:0] m_cnt;
  logic [31:0] m_tid;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [13:0] a);
    if (a == CSR_TCFG)  return 32'(m_init * 4 + (m_per ? 2 : 0) + (m_en ? 1 : 0));
    if (a == CSR_TVAL)  return 32'(m_tval);
    if (a == CSR_TID)   return m_tid;
    return 32'h0;
  endfunction

  function automatic bit model_hit(input logic [13:0] a);
    return (a == CSR_TCFG) || (a == CSR_TVAL) || (a == CSR_TICLR) || (a == CSR_TID);
  endfunction

  // one clock of architectural behaviour, using the inputs applied this cycle
  task automatic model_step();
    bit expire;
    if (rst) begin
      m_en = 0; m_per = 0; m_init = 0; m_tval = 0; m_ti = 0;
      m_cnt = 64'd0; m_tid = TID_RST; m_valid = 1'b1;
    end else begin
      m_cnt = m_cnt + 64'd1;
      if (csr_we && csr_waddr == CSR_TID) m_tid = csr_wdata;
      expire = m_en && (m_tval == 1);
      if (csr_we && csr_waddr == CSR_TCFG) begin
        m_en   = csr_wdata[0];
        m_per  = csr_wdata[1];
        m_init = (csr_wdata >> 2) % 4096;
        m_tval = m_init * 4;
        if (m_en && m_tval == 0) expire = 1;
      end else if (m_en) begin
        if (m_tval > 0) m_tval = m_tval - 1;
        else if (m_per) begin
          m_tval = m_init * 4;
          if (m_tval == 0) expire = 1;
        end else m_en = 0;
      end
      if (expire) m_ti = 1;
      else if (csr_we && csr_waddr == CSR_TICLR && csr_wdata[0]) m_ti = 0;
    end
  endtask

  // apply inputs for one cycle, check the pre-edge read, clock, then check everything
  task automatic cyc(input bit r, input bit we, input logic [13:0] wa,
                     input logic [31:0] wd, input logic [13:0] ra);
    rst = r; csr_we = we; csr_waddr = wa; csr_wdata = wd; csr_raddr = ra;
    #1;
    if (m_valid) check_val("rdata_pre", csr_rdata, model_read(ra));
    @(posedge clk);
    model_step();
    #1;
    check_val("rdata", csr_rdata, model_read(ra));
    check_val("rhit", csr_rhit, model_hit(ra));
    check_val("timer_int", timer_int, m_ti);
    check_val("cnt_lo", cnt_lo, m_cnt[31:0]);
    check_val("cnt_hi", cnt_hi, m_cnt[63:32]);
    check_val("tid", tid, m_tid);
  endtask

  task automatic idle(input int n, input logic [13:0] ra);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 14'h0, 32'h0, ra);
  endtask

  task automatic wr(input logic [13:0] wa, input logic [31:0] wd, input logic [13:0] ra);
    cyc(1'b0, 1'b1, wa, wd, ra);
  endtask

  logic [13:0] raddr_tab [6] = '{CSR_TID, CSR_TCFG, CSR_TVAL, CSR_TICLR, 14'h0000, 14'h0043};

  initial begin
    rst = 1'b1; csr_we = 1'b0; csr_waddr = 14'h0; csr_wdata = 32'h0; csr_raddr = CSR_TCFG;

    // reset
    cyc(1'b1, 1'b0, 14'h0, 32'h0, CSR_TCFG);
    cyc(1'b1, 1'b0, 14'h0, 32'h0, CSR_TCFG);
    check_val("rst_tcfg", csr_rdata, 64'h0);
    check_val("rst_ti", timer_int, 64'h0);
    check_val("rst_cnt", cnt_lo, 64'h0);
    check_val("rst_tid", tid, TID_RST);
    idle(5, CSR_TVAL);
    check_val("rst_tval", csr_rdata, 64'h0);
    check_val("cnt_after5", cnt_lo, 64'd5);

    // one-shot
    wr(CSR_TCFG, 32'h0000_000D, CSR_TVAL);
    check_val("os_tval_n1", csr_rdata, 64'h00C);
    idle(12, CSR_TVAL);
    check_val("os_tval_n13", csr_rdata, 64'h0);
    check_val("os_ti_n13", timer_int, 64'h1);
    idle(3, CSR_TCFG);
    check_val("os_tcfg_after", csr_rdata, 64'h0000_000C);
    idle(1, CSR_TVAL);
    check_val("os_tval_hold", csr_rdata, 64'h0);

    // periodic
    wr(CSR_TICLR, 32'h1, CSR_TVAL);
    wr(CSR_TCFG, 32'h0000_000F, CSR_TVAL);
    idle(12, CSR_TVAL);
    check_val("per_tval_n13", csr_rdata, 64'h0);
    check_val("per_ti_n13", timer_int, 64'h1);
    idle(1, CSR_TVAL);
    check_val("per_reload_n14", csr_rdata, 64'h00C);
    wr(CSR_TICLR, 32'hFFFF_FFF1, CSR_TICLR);
    check_val("per_ticlr_read", csr_rdata, 64'h0);
    check_val("per_ti_cleared", timer_int, 64'h0);
    idle(11, CSR_TVAL);
    check_val("per_tval_n26", csr_rdata, 64'h0);
    check_val("per_ti_n26", timer_int, 64'h1);

    // set/clear collision
    wr(CSR_TCFG, 32'h0000_000D, CSR_TVAL);
    wr(CSR_TICLR, 32'h1, CSR_TVAL);
    idle(10, CSR_TVAL);
    check_val("col_tval1", csr_rdata, 64'h1);
    check_val("col_ti_before", timer_int, 64'h0);
    wr(CSR_TICLR, 32'h1, CSR_TVAL);
    check_val("col_ti", timer_int, 64'h1);

    // TCFG write in the cycle TVAL reaches 1: write wins, TI still set
    wr(CSR_TICLR, 32'h1, CSR_TVAL);
    wr(CSR_TCFG, 32'h0000_0009, CSR_TVAL);
    idle(7, CSR_TVAL);
    check_val("tw_tval1", csr_rdata, 64'h1);
    wr(CSR_TCFG, 32'h0000_0015, CSR_TVAL);
    check_val("tw_tval", csr_rdata, 64'h014);
    check_val("tw_ti", timer_int, 64'h1);

    // freeze and ignore TVAL writes
    wr(CSR_TCFG, 32'h0000_000D, CSR_TVAL);
    idle(3, CSR_TVAL);
    wr(CSR_TCFG, 32'h0000_000C, CSR_TVAL);
    wr(CSR_TICLR, 32'h1, CSR_TVAL);
    for (int i = 0; i < 20; i++) begin
      idle(1, CSR_TVAL);
      check_val("frz_tval", csr_rdata, 64'h00C);
      check_val("frz_ti", timer_int, 64'h0);
    end
    wr(CSR_TVAL, 32'h5, CSR_TVAL);
    check_val("tval_ro", csr_rdata, 64'h00C);

    // reset mid-count
    wr(CSR_TCFG, 32'h0000_000D, CSR_TVAL);
    idle(7, CSR_TVAL);
    check_val("mid_tval5", csr_rdata, 64'h005);
    cyc(1'b1, 1'b0, 14'h0, 32'h0, CSR_TVAL);
    check_val("mid_rst_tval", csr_rdata, 64'h0);
    check_val("mid_rst_ti", timer_int, 64'h0);
    check_val("mid_rst_cnt", {cnt_hi, cnt_lo}, 64'h0);
    idle(15, CSR_TVAL);
    check_val("mid_no_ti", timer_int, 64'h0);

    // counter wrap via deposit
    force dut.u_stable_counter.cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.u_stable_counter.cnt_r;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(1, CSR_TID);
    check_val("wrap_hi", cnt_hi, 64'h0);
    check_val("wrap_lo", cnt_lo, 64'h0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int unsigned op;
      logic [31:0] wd;
      logic [13:0] ra;
      op = $urandom_range(0, 99);
      wd = $urandom;
      ra = raddr_tab[$urandom_range(0, 5)];
      if (op < 2) cyc(1'b1, 1'b0, 14'h0, wd, ra);
      else if (op < 14) begin
        wd[13:2] = 12'($urandom_range(0, 5));
        wr(CSR_TCFG, wd, ra);
      end
      else if (op < 24) wr(CSR_TICLR, wd, ra);
      else if (op < 29) wr(CSR_TID, wd, ra);
      else if (op < 34) wr(CSR_TVAL, wd, ra);
      else if (op < 38) wr(14'h0043, wd, ra);
      else idle(1, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
